// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned AW_DEF  = 32;
  localparam int unsigned DW_DEF  = 32;
  localparam int unsigned TMO_DEF = 255;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_INST = 2'd2
  } arb_state_e;

  // Width of the timeout counter, wide enough to hold TMO itself
  function automatic int unsigned tmo_cnt_w(input int unsigned tmo);
    return (tmo < 2) ? 1 : $clog2(tmo + 1);
  endfunction

endpackage

// File: rtl/mem_arb_ibuf.sv
// One-entry instruction fetch buffer (address, data, valid).
// Only instantiated when MEM_ARB_IBUF_EN is defined.
module mem_arb_ibuf
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] lookup_addr_i,
  input  logic          fill_i,
  input  logic [AW-1:0] fill_addr_i,
  input  logic [DW-1:0] fill_data_i,
  input  logic          inv_i,
  input  logic [AW-1:0] inv_addr_i,
  output logic          hit_c_o,
  output logic [DW-1:0] data_o
);

  logic          valid_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;

  // Fill on a successful fetch; drop the entry when a write lands on its address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
      addr_q  <= fill_addr_i;
      data_q  <= fill_data_i;
    end else if (inv_i && (inv_addr_i == addr_q)) begin
      valid_q <= 1'b0;
    end
  end

  assign hit_c_o = valid_q & (addr_q == lookup_addr_i);
  assign data_o  = data_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one variable-latency memory between the CPU fetch and data
// ports. Data wins ties; a fetch pending at data completion follows with no gap.
// Optional one-entry fetch buffer enabled by defining MEM_ARB_IBUF_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW  = AW_DEF,
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned TMO = TMO_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_data,
  output logic          if_valid,
  input  logic          d_rd,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          err,
  output logic          stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CW = tmo_cnt_w(TMO);

  localparam logic [1:0] IDLE = 2'(ST_IDLE);
  localparam logic [1:0] DATA = 2'(ST_DATA);
  localparam logic [1:0] INST = 2'(ST_INST);

  logic [1:0]    state_q,     state_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic          mem_req_q,   mem_req_d;
  logic          mem_we_q,    mem_we_d;
  logic [AW-1:0] mem_addr_q,  mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_data_q,   if_data_d;
  logic          if_valid_q,  if_valid_d;
  logic [DW-1:0] d_rdata_q,   d_rdata_d;
  logic          d_valid_q,   d_valid_d;
  logic          err_q,       err_d;

  logic          d_req_c;
  logic          i_req_c;
  logic          tmo_hit_c;
  logic          ib_hit_c;
  logic [DW-1:0] ib_data_c;

  // A requester is still holding its line during its own valid pulse; ignore it then
  assign d_req_c   = (d_rd | d_wr) & ~d_valid_q;
  assign i_req_c   = if_req & ~if_valid_q;
  assign tmo_hit_c = (cnt_q == CW'(TMO - 1));

`ifdef MEM_ARB_IBUF_EN
  logic ib_fill_c;
  logic ib_inv_c;

  assign ib_fill_c = (state_q == INST) & mem_ready;
  assign ib_inv_c  = (state_q == DATA) & mem_ready & mem_we_q;

  mem_arb_ibuf #(
    .AW (AW),
    .DW (DW)
  ) u_ibuf (
    .clk           (clk),
    .rst           (rst),
    .lookup_addr_i (if_addr),
    .fill_i        (ib_fill_c),
    .fill_addr_i   (mem_addr_q),
    .fill_data_i   (mem_rdata),
    .inv_i         (ib_inv_c),
    .inv_addr_i    (mem_addr_q),
    .hit_c_o       (ib_hit_c),
    .data_o        (ib_data_c)
  );
`else
  assign ib_hit_c  = 1'b0;
  assign ib_data_c = '0;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_data_d   = if_data_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_req_c) begin
          state_d     = DATA;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = d_wr;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end else if (i_req_c) begin
          if (ib_hit_c) begin
            if_valid_d = 1'b1;
            if_data_d  = ib_data_c;
          end else begin
            state_d    = INST;
            cnt_d      = '0;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = if_addr;
          end
        end
      end

      DATA: begin
        if (mem_ready) begin
          d_rdata_d = mem_rdata;
          d_valid_d = 1'b1;
          if (i_req_c) begin
            state_d    = INST;
            cnt_d      = '0;
            mem_we_d   = 1'b0;
            mem_addr_d = if_addr;
          end else begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
          end
        end else if (tmo_hit_c) begin
          d_rdata_d = '0;
          d_valid_d = 1'b1;
          err_d     = 1'b1;
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      INST: begin
        if (mem_ready) begin
          if_data_d  = mem_rdata;
          if_valid_d = 1'b1;
          state_d    = IDLE;
          mem_req_d  = 1'b0;
        end else if (tmo_hit_c) begin
          if_data_d  = '0;
          if_valid_d = 1'b1;
          err_d      = 1'b1;
          state_d    = IDLE;
          mem_req_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset kills any in-flight access at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_data_q   <= '0;
      if_valid_q  <= 1'b0;
      d_rdata_q   <= '0;
      d_valid_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_data_q   <= if_data_d;
      if_valid_q  <= if_valid_d;
      d_rdata_q   <= d_rdata_d;
      d_valid_q   <= d_valid_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_data   = if_data_q;
  assign if_valid  = if_valid_q;
  assign d_rdata   = d_rdata_q;
  assign d_valid   = d_valid_q;
  assign err       = err_q;
  assign stall     = (if_req & ~if_valid_q) | ((d_rd | d_wr) & ~d_valid_q);

endmodule
